// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, source
// indices, FSM state type and the priority-encoder result record.
package int_ctrl_pkg;

  localparam logic [1:0] INT_PEND = 2'd0;
  localparam logic [1:0] INT_MASK = 2'd1;
  localparam logic [1:0] INT_MODE = 2'd2;
  localparam logic [1:0] INT_STAT = 2'd3;

  localparam int INT_TIMER = 0;
  localparam int INT_UART  = 1;
  localparam int INT_BT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } prio_t;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Register bus and CPU interrupt handshake of the interrupt controller.
interface int_ctrl_if #(
  parameter int DW = 16
);
  logic          reg_sel;
  logic          reg_we;
  logic [1:0]    reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic          int_req;
  logic [2:0]    int_id;
  logic          int_ack;
  logic          int_eoi;

  modport master (
    output reg_sel, reg_we, reg_addr, reg_wdata, int_ack, int_eoi,
    input  reg_rdata, int_req, int_id
  );

  modport slave (
    input  reg_sel, reg_we, reg_addr, reg_wdata, int_ack, int_eoi,
    output reg_rdata, int_req, int_id
  );
endinterface

// File: rtl/int_ctrl_prio_enc8.sv
// Fixed-priority encoder over eight requests; the lowest set index wins.
module prio_enc8
  import int_ctrl_pkg::*;
(
  input  logic [7:0] vec_i,
  output prio_t      pick_o
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_o = '0;
    for (int i = 7; i >= 0; i--) begin
      if (vec_i[i]) begin
        pick_o.valid = 1'b1;
        pick_o.idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Eight-source interrupt controller: pending/mask/mode registers, fixed
// priority arbitration and a request/service handshake FSM.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  int_ctrl_if.slave       bus
);

  logic [7:0] src_q, src_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] mode_q, mode_d;
  state_e     state_q, state_d;
  logic       int_req_q, int_req_d;
  logic [2:0] int_id_q, int_id_d;
  logic       in_service_q, in_service_d;

  logic [7:0]    src;
  logic [7:0]    pending;
  logic [7:0]    cand;
  logic [7:0]    cand_nxt;
  logic [7:0]    edge_set;
  logic [7:0]    w1c;
  logic [7:0]    ack_clr;
  logic          reg_wr;
  prio_t         pick;
  logic [DW-1:0] rdata;
  logic          unused_wdata_hi;

  assign src             = irq_src;
  assign unused_wdata_hi = ^bus.reg_wdata[DW-1:8];

  // Level-mode bits follow the source directly; only edge-mode bits are stored.
  assign pending  = (mode_q & pend_q) | (~mode_q & src);
  assign cand     = pending & mask_q;
  assign edge_set = src & ~src_q;
  assign reg_wr   = bus.reg_sel & bus.reg_we;

  prio_enc8 u_prio (
    .vec_i  (cand),
    .pick_o (pick)
  );

  always_comb begin
    src_d   = src;
    mask_d  = mask_q;
    mode_d  = mode_q;
    w1c     = '0;
    ack_clr = '0;
    if (reg_wr) begin
      case (bus.reg_addr)
        INT_PEND: w1c    = bus.reg_wdata[7:0];
        INT_MASK: mask_d = bus.reg_wdata[7:0];
        INT_MODE: mode_d = bus.reg_wdata[7:0];
        default:  ;
      endcase
    end
    if (state_q == ST_REQ && bus.int_ack) begin
      ack_clr = onehot8(int_id_q);
    end
    // A new edge is OR-ed in after the clears so it survives a same-cycle clear.
    pend_d   = ((pend_q & ~w1c & ~ack_clr) | edge_set) & mode_d;
    cand_nxt = ((mode_d & pend_d) | (~mode_d & src)) & mask_d;
  end

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    case (state_q)
      ST_IDLE: begin
        if (pick.valid) begin
          state_d   = ST_REQ;
          int_req_d = 1'b1;
          int_id_d  = pick.idx;
        end
      end
      ST_REQ: begin
        // Ack wins over withdrawal and over a simultaneous eoi.
        if (bus.int_ack) begin
          state_d      = ST_SERVICE;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
        end else if (!cand_nxt[int_id_q]) begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (bus.int_eoi) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    src_q <= src_d;
    if (rst) begin
      pend_q       <= '0;
      mask_q       <= 8'h00;
      mode_q       <= 8'hFF;
      state_q      <= ST_IDLE;
      int_req_q    <= 1'b0;
      int_id_q     <= 3'd0;
      in_service_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.reg_addr)
      INT_PEND: rdata[7:0]  = pending;
      INT_MASK: rdata[7:0]  = mask_q;
      INT_MODE: rdata[7:0]  = mode_q;
      INT_STAT: rdata[15:0] = {in_service_q, int_req_q, 3'b000, int_id_q, 8'h00};
      default:  rdata       = '0;
    endcase
  end

  assign bus.reg_rdata = rdata;
  assign bus.int_req   = int_req_q;
  assign bus.int_id    = int_id_q;

endmodule
